// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I datapath: Moore decode, state-derived controls registered alongside state.
// Memory states stall on mem_ready (when USE_MEM_READY=1); write enables are gated low combinationally during reset.
module multicycle_main_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_update,
  output logic       branch,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       pc_on_rdy;
    logic       branch;
    logic       ir_on_rdy;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctl_t;

  state_t state_q;
  ctl_t   ctl_q;
  logic   rdy;

  assign rdy = USE_MEM_READY ? mem_ready : 1'b1;

  function automatic state_t next_state(input state_t s, input logic [6:0] op, input logic r);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:    n = r ? DECODE : FETCH;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: n = MEMADR;
          7'b0110011:             n = EXECR;
          7'b0010011:             n = EXECI;
          7'b1101111:             n = JAL;
          7'b1100011:             n = BEQ;
          default:                n = TRAP;
        endcase
      end
      MEMADR:   n = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  n = r ? MEMWB : MEMREAD;
      MEMWB:    n = FETCH;
      MEMWRITE: n = r ? FETCH : MEMWRITE;
      EXECR:    n = ALUWB;
      EXECI:    n = ALUWB;
      ALUWB:    n = FETCH;
      JAL:      n = ALUWB;
      BEQ:      n = FETCH;
      TRAP:     n = FETCH;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  // Handshake-dependent FETCH enables are kept as qualifiers and combined with rdy at the port.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.pc_on_rdy  = 1'b1;
        c.ir_on_rdy  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      ALUWB:    c.reg_write = 1'b1;
      EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      TRAP:     c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // ctl_q always holds decode(state_q), so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctl_q   <= decode(FETCH);
    end else begin
      state_q <= next_state(state_q, opcode, rdy);
      ctl_q   <= decode(next_state(state_q, opcode, rdy));
    end
  end

  assign state         = state_q;
  assign pc_update     = rst_n & (ctl_q.pc_update | (ctl_q.pc_on_rdy & rdy));
  assign ir_write      = rst_n & ctl_q.ir_on_rdy & rdy;
  assign branch        = rst_n & ctl_q.branch;
  assign reg_write     = rst_n & ctl_q.reg_write;
  assign mem_write     = rst_n & ctl_q.mem_write;
  assign illegal_instr = rst_n & ctl_q.illegal;
  assign adr_src       = ctl_q.adr_src;
  assign result_src    = ctl_q.result_src;
  assign alu_src_a     = ctl_q.alu_src_a;
  assign alu_src_b     = ctl_q.alu_src_b;
  assign alu_op        = ctl_q.alu_op;

  always_comb begin
    imm_src = 2'b00;
    case (opcode)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Main control state machine for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback. It produces the datapath enables and mux selects, plus the 2-bit ALUOp consumed by the ALU decoder stage directly downstream. It also adds memory wait-state handshaking and illegal-opcode trapping.

Parameters:
USE_MEM_READY, 1, when 1 memory states wait for mem_ready; when 0 mem_ready is ignored and treated as 1.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  instr[6:0] from instruction register
mem_ready  input  1  memory access completes this cycle
state  output  4  current state encoding (debug/verification)
pc_update  output  1  PC write enable (unconditional)
branch  output  1  branch candidate; datapath ANDs with zero flag
ir_write  output  1  instruction register / OldPC load
reg_write  output  1  register file write enable
mem_write  output  1  data memory write enable
adr_src  output  1  0 = PC, 1 = ALU result as memory address
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
alu_op  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
imm_src  output  2  combinational from opcode: 00 I/lw, 01 sw, 10 beq, 11 jal, else 00
illegal_instr  output  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM. State register is 4 bits. All outputs except imm_src decode from state, plus mem_ready where noted.
- Any output not listed for a state is 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 11. Codes 12–15 are unreachable; if entered, next state is FETCH and all outputs are 0.
- Reset: rst_n low at a rising edge sets state to FETCH. This applies mid-instruction too; the pending instruction is abandoned.
- While rst_n is low, pc_update, ir_write, reg_write, mem_write, branch and illegal_instr are forced to 0 combinationally.
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10. ir_write and pc_update equal mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a 01, alu_src_b 01, alu_op 00.
- DECODE transitions by opcode:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1101111 goes to JAL.
  - 1100011 goes to BEQ.
  - Any other opcode goes to TRAP.
- MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00. Next state is MEMREAD if opcode[5] = 0, else MEMWRITE.
- MEMREAD: adr_src 1, result_src 00. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src 01, reg_write 1, then go to FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1 held every cycle until mem_ready. Return to FETCH on the mem_ready cycle.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10, then go to ALUWB.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10, then go to ALUWB.
- ALUWB: result_src 00, reg_write 1, then go to FETCH.
- JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1, then go to ALUWB.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1, then go to FETCH.
- TRAP: illegal_instr 1 for exactly one cycle, no enables asserted, then go to FETCH.
- opcode is sampled every cycle. The instruction register holds it stable from DECODE onward.
- Cycle counts with mem_ready tied high:
  - lw 5 cycles, sw 4, R-type 4, I-type 4.
  - jal 4 (FETCH, DECODE, JAL, ALUWB), beq 3.
  - illegal 3 (FETCH, DECODE, TRAP).
- Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
- Reset held 2 cycles, then release with mem_ready=1 and opcode=0110011: states 0,1,6,7,0. alu_op=10 in EXECR. reg_write=1 only in ALUWB.
- opcode=0000011, mem_ready low for 2 cycles in MEMREAD: states 0,1,2,3,3,3,4,0. adr_src=1 throughout MEMREAD. reg_write=1 with result_src=01 in MEMWB. imm_src=00.
- opcode=0100011, mem_ready low 1 cycle in MEMWRITE: states 0,1,2,5,5,0. mem_write=1 for both MEMWRITE cycles. imm_src=01. reg_write never asserted.
- opcode=1100011 then 1101111: beq gives states 0,1,10,0 with branch=1 and alu_op=01 in state 10. jal gives 0,1,9,7,0 with pc_update=1 in 9 and reg_write=1 in 7.
- opcode=1110011 (unsupported): states 0,1,11,0. illegal_instr is a single one-cycle pulse in state 11, and no write enable is asserted.
- rst_n driven low in MEMWRITE while mem_write=1: mem_write drops to 0 immediately, and the state is FETCH after the edge. FETCH with mem_ready=0 holds with ir_write=0 and pc_update=0. USE_MEM_READY=0 with mem_ready=0 still yields the lw sequence 0,1,2,3,4,0.
